// File: rtl/acq_pkg.sv
// Shared types and default widths for the SPI acquisition sequencer.
package acq_pkg;

  localparam int unsigned ACQ_DATA_W = 16;
  localparam int unsigned ACQ_CNT_W  = 8;
  localparam int unsigned ACQ_TMR_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TICK = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_FINISH    = 2'd3
  } acq_state_e;

endpackage : acq_pkg

// File: rtl/spi_acq_ctrl.sv
// Acquisition sequencer: enables the period timer, launches one SPI
// conversion per timer tick, collects nsamp words, flags overruns.
// Optional burst accumulator (sum_o) is built when ACQ_ACCUM_EN is defined.
module spi_acq_ctrl
  import acq_pkg::*;
#(
  parameter int unsigned Width     = ACQ_TMR_W,
  parameter int unsigned DataWidth = ACQ_DATA_W,
  parameter int unsigned CntWidth  = ACQ_CNT_W
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [CntWidth-1:0]           nsamp_i,
  input  logic [Width-1:0]              period_i,
  input  logic                          tick_i,
  output logic                          tmr_en_o,
  output logic [Width-1:0]              tmr_kmax_o,
  output logic                          spi_start_o,
  input  logic                          spi_done_i,
  input  logic [DataWidth-1:0]          spi_data_i,
  output logic [DataWidth-1:0]          data_o,
  output logic                          data_valid_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          ovr_o
`ifdef ACQ_ACCUM_EN
  ,
  output logic [DataWidth+CntWidth-1:0] sum_o
`endif
);

  acq_state_e           state_q, state_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [CntWidth-1:0]  nsamp_q, nsamp_d;
  logic [CntWidth-1:0]  cnt_inc;
  logic                 en_q, en_d;
  logic [Width-1:0]     kmax_q, kmax_d;
  logic                 spi_start_q, spi_start_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ovr_q, ovr_d;
`ifdef ACQ_ACCUM_EN
  logic [DataWidth+CntWidth-1:0] sum_q, sum_d;
`endif

  // State register and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      nsamp_q     <= '0;
      en_q        <= 1'b0;
      kmax_q      <= '0;
      spi_start_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
`ifdef ACQ_ACCUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nsamp_q     <= nsamp_d;
      en_q        <= en_d;
      kmax_q      <= kmax_d;
      spi_start_q <= spi_start_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
`ifdef ACQ_ACCUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  // Next-state and next-output logic; abort overrides every other event.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nsamp_d     = nsamp_q;
    en_d        = en_q;
    kmax_d      = kmax_q;
    spi_start_d = 1'b0;
    data_d      = data_q;
    valid_d     = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ovr_d       = ovr_q;
    cnt_inc     = cnt_q + CntWidth'(1);
`ifdef ACQ_ACCUM_EN
    sum_d       = sum_q;
`endif

    if (abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      en_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            cnt_d = '0;
            ovr_d = 1'b0;
`ifdef ACQ_ACCUM_EN
            sum_d = '0;
`endif
            if (nsamp_i != '0) begin
              nsamp_d = nsamp_i;
              kmax_d  = period_i;
              en_d    = 1'b1;
              busy_d  = 1'b1;
              state_d = ST_WAIT_TICK;
            end else begin
              state_d = ST_FINISH;
            end
          end
        end
        ST_WAIT_TICK: begin
          if (tick_i) begin
            spi_start_d = 1'b1;
            state_d     = ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          // A tick while a conversion is outstanding is dropped, not queued.
          if (tick_i) begin
            ovr_d = 1'b1;
          end
          if (spi_done_i) begin
            data_d  = spi_data_i;
            valid_d = 1'b1;
            cnt_d   = cnt_inc;
`ifdef ACQ_ACCUM_EN
            sum_d   = sum_q + {{CntWidth{1'b0}}, spi_data_i};
`endif
            state_d = (cnt_inc == nsamp_q) ? ST_FINISH : ST_WAIT_TICK;
          end
        end
        ST_FINISH: begin
          en_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign tmr_en_o     = en_q;
  assign tmr_kmax_o   = kmax_q;
  assign spi_start_o  = spi_start_q;
  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign ovr_o        = ovr_q;
`ifdef ACQ_ACCUM_EN
  assign sum_o        = sum_q;
`endif

endmodule : spi_acq_ctrl
